// File: rtl/divider.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first, IDLE/RUN/DONE control.
// Optional DIVIDER_DIVZERO_FAST_EN: a zero divisor skips RUN and reaches DONE one cycle after start.
module divider #(
    parameter int N = 16,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [D-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [D-1:0] remainder,
    output logic         dz,
    output logic [1:0]   state_dbg
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   dvd_q, dvd_d;
    logic [D-1:0]   dvs_q, dvs_d;
    logic [D-1:0]   rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [D-1:0]   rout_q, rout_d;
    logic           dz_q, dz_d;
    logic           fz_q, fz_d;

    logic [D:0]     rem_shift;
    logic [D-1:0]   rem_next;
    logic [N-1:0]   dvd_next;
    logic           q_bit;
    logic           accept;

    // Datapath step. A kept remainder is always below the divisor, so the
    // subtraction result fits in D bits and the carry bit only feeds the compare.
    // With a zero divisor every step subtracts nothing, giving all-ones quotient
    // and the dividend's low D bits as remainder without special casing.
    always_comb begin
        rem_shift = {rem_q, dvd_q[N-1]};
        q_bit     = rem_shift[D] | (rem_shift[D-1:0] >= dvs_q);
        rem_next  = q_bit ? (rem_shift[D-1:0] - dvs_q) : rem_shift[D-1:0];
        dvd_next  = {dvd_q[N-2:0], q_bit};
        accept    = start && !fz_q && ((state_q == IDLE) || (state_q == DONE));
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rout_d  = rout_q;
        dz_d    = dz_q;
        fz_d    = fz_q;
        case (state_q)
            IDLE, DONE: begin
                if (fz_q) begin
                    // Fast zero-divisor request waiting one cycle before DONE.
                    state_d = DONE;
                    fz_d    = 1'b0;
                    quot_d  = '1;
                    rout_d  = dvd_q[D-1:0];
                    dz_d    = 1'b1;
                end else if (accept) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    rem_d = '0;
                    cnt_d = CW'(N - 1);
                    dz_d  = 1'b0;
`ifdef DIVIDER_DIVZERO_FAST_EN
                    if (divisor == '0) begin
                        state_d = IDLE;
                        fz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
`else
                    state_d = RUN;
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = rem_next;
                dvd_d = dvd_next;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quot_d  = dvd_next;
                    rout_d  = rem_next;
                    dz_d    = (dvs_q == '0);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rout_q  <= '0;
            dz_q    <= 1'b0;
            fz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rout_q  <= rout_d;
            dz_q    <= dz_d;
            fz_q    <= fz_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = rout_q;
    assign dz        = dz_q;
    assign state_dbg = state_q;

endmodule
